// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the memory controller.
//   state_e    - controller FSM states
//   LEN_*      - load/store length codes as seen on mem_len_i
//   len_bytes  - byte count of a load/store (code 3 is treated as a word)
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IF_RD  = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        logic [2:0] n;
        case (len)
            LEN_B:   n = 3'd1;
            LEN_H:   n = 3'd2;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// mem_byte_lane: byte-lane helper shared by reads and writes.
//   word_i  in  32  source word (store data or partial load result)
//   lane_i  in  2   byte lane 0..3 (little-endian)
//   byte_i  in  8   byte to insert into lane_i
//   byte_o  out 8   byte of word_i at lane_i (store path)
//   word_o  out 32  word_i with lane_i replaced by byte_i (load path)
module mem_byte_lane (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [7:0]  byte_o,
    output logic [31:0] word_o
);

    always_comb begin
        byte_o = word_i[{lane_i, 3'b000} +: 8];
        word_o = word_i;
        word_o[{lane_i, 3'b000} +: 8] = byte_i;
    end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetches and load/stores onto a byte-wide RAM.
//   clk, rst                     clock, asynchronous active-low reset
//   if_req_i/if_addr_i/if_flush_i fetch request, address, abort
//   if_data_o/if_done_o           fetched word, completion pulse
//   mem_req_i/mem_we_i/mem_len_i  load/store request, direction, length
//   mem_addr_i/mem_wdata_i        load/store address, store data
//   mem_rdata_o/mem_done_o        load data (zero-extended), completion pulse
//   ram_addr_o/ram_we_o/ram_dout_o byte RAM address, write enable, write byte
//   ram_din_i                     RAM read byte, one cycle after its address
//   busy_o                        high whenever the FSM is not in IDLE
//
// Handshake: a requester raises its req level and holds it, with stable
// operands, until it sees its done pulse; operands are captured in the grant
// cycle, and done is a single-cycle pulse from DONE, after which the FSM
// returns to IDLE and may grant again.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_flush_i,
    output logic [31:0] if_data_o,
    output logic        if_done_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_len_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic [31:0] ram_addr_o,
    output logic        ram_we_o,
    output logic [7:0]  ram_dout_o,
    input  logic [7:0]  ram_din_i,
    output logic        busy_o
);

    state_e      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic [2:0]  nbytes_q, nbytes_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        is_if_q, is_if_d;

    logic [31:0] cur_addr;
    logic [1:0]  lane;
    logic [31:0] lane_word;
    logic [7:0]  lane_byte;
    logic [31:0] lane_merged;

    // cnt_q counts busy cycles from 0; the address issued in a cycle is base+cnt.
    assign cur_addr = base_q + {29'd0, cnt_q};

    // Reads land one cycle after their address, so the byte arriving now
    // belongs to lane cnt-1; stores emit lane cnt directly.
    assign lane      = (state_q == ST_MEM_WR) ? cnt_q[1:0] : (cnt_q[1:0] - 2'd1);
    assign lane_word = (state_q == ST_MEM_WR) ? wdata_q : acc_q;

    mem_byte_lane u_lane (
        .word_i (lane_word),
        .lane_i (lane),
        .byte_i (ram_din_i),
        .byte_o (lane_byte),
        .word_o (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        nbytes_d    = nbytes_q;
        cnt_d       = cnt_q;
        is_if_d     = is_if_q;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_dout_o  = '0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                acc_d = '0;
                if (mem_req_i) begin
                    base_d   = mem_addr_i;
                    wdata_d  = mem_wdata_i;
                    nbytes_d = len_bytes(mem_len_i);
                    is_if_d  = 1'b0;
                    state_d  = mem_we_i ? ST_MEM_WR : ST_MEM_RD;
                end else if (if_req_i && !if_flush_i) begin
                    base_d   = if_addr_i;
                    nbytes_d = 3'd4;
                    is_if_d  = 1'b1;
                    state_d  = ST_IF_RD;
                end
            end

            ST_IF_RD, ST_MEM_RD: begin
                if (cnt_q < nbytes_q) begin
                    ram_addr_o = cur_addr;
                end
                if (state_q == ST_IF_RD && if_flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        acc_d = lane_merged;
                    end
                    // The extra cycle at cnt==N only collects the last byte.
                    if (cnt_q == nbytes_q) begin
                        state_d = ST_DONE;
                        if (is_if_q) begin
                            if_data_d = lane_merged;
                        end else begin
                            mem_rdata_d = lane_merged;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            ST_MEM_WR: begin
                ram_we_o   = 1'b1;
                ram_addr_o = cur_addr;
                ram_dout_o = lane_byte;
                if (cnt_q == nbytes_q - 3'd1) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
            nbytes_q    <= '0;
            cnt_q       <= '0;
            is_if_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            nbytes_q    <= nbytes_d;
            cnt_q       <= cnt_d;
            is_if_q     <= is_if_d;
        end
    end

    assign if_data_o   = if_data_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_done_o   = (state_q == ST_DONE) && is_if_q;
    assign mem_done_o  = (state_q == ST_DONE) && !is_if_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed bench for mem_ctrl with a byte RAM
// model, a per-cycle expected-output trace and a compare process.
module tb_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic [31:0] if_data_o;
    logic        if_done_o;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_len_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;
    logic [31:0] ram_addr_o;
    logic        ram_we_o;
    logic [7:0]  ram_dout_o;
    logic [7:0]  ram_din_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_data_o   (if_data_o),
        .if_done_o   (if_done_o),
        .mem_req_i   (mem_req_i),
        .mem_we_i    (mem_we_i),
        .mem_len_i   (mem_len_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_done_o  (mem_done_o),
        .ram_addr_o  (ram_addr_o),
        .ram_we_o    (ram_we_o),
        .ram_dout_o  (ram_dout_o),
        .ram_din_i   (ram_din_i),
        .busy_o      (busy_o)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM and model memory ----------------
    logic [7:0] ram [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];

    function automatic logic [7:0] fill_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return fill_byte(a);
    endfunction

    function automatic logic [7:0] mm_rd(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return fill_byte(a);
    endfunction

    always @(posedge clk) begin
        ram_din_i <= ram_rd(ram_addr_o);
        if (ram_we_o) ram[ram_addr_o] = ram_dout_o;
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] b);
        ram[a]       = b;
        model_mem[a] = b;
    endtask

    // ---------------- expected trace ----------------
    typedef struct packed {
        logic        busy;
        logic        care_ad;
        logic [31:0] addr;
        logic        we;
        logic [7:0]  dout;
        logic        if_done;
        logic        mem_done;
        logic        upd_if;
        logic        upd_mem;
        logic [31:0] data;
        logic        is_rst;
    } rec_t;

    rec_t exp_q[$];

    function automatic rec_t mk(input logic busy, input logic care, input logic [31:0] addr,
                                input logic we, input logic [7:0] dout);
        rec_t r;
        r         = '0;
        r.busy    = busy;
        r.care_ad = care;
        r.addr    = addr;
        r.we      = we;
        r.dout    = dout;
        return r;
    endfunction

    function automatic rec_t mk_rst();
        rec_t r;
        r         = mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0);
        r.is_rst  = 1'b1;
        return r;
    endfunction

    // Whole transaction from grant cycle 0 to the done cycle.
    function automatic void push_txn(input bit is_if, input bit we, input logic [1:0] len,
                                     input logic [31:0] base, input logic [31:0] wdata);
        int          n;
        logic [31:0] rd;
        rec_t        r;
        n  = is_if ? 4 : (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        rd = '0;
        exp_q.push_back(mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0));
        if (we) begin
            for (int c = 1; c <= n; c++) begin
                exp_q.push_back(mk(1'b1, 1'b1, base + 32'(c - 1), 1'b1, wdata[8*(c-1) +: 8]));
                model_mem[base + 32'(c - 1)] = wdata[8*(c-1) +: 8];
            end
            r          = mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
            r.mem_done = 1'b1;
            exp_q.push_back(r);
        end else begin
            for (int c = 1; c <= n; c++) begin
                exp_q.push_back(mk(1'b1, 1'b1, base + 32'(c - 1), 1'b0, 8'd0));
                rd[8*(c-1) +: 8] = mm_rd(base + 32'(c - 1));
            end
            exp_q.push_back(mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0));
            r      = mk(1'b1, 1'b0, 32'd0, 1'b0, 8'd0);
            r.data = rd;
            if (is_if) begin
                r.if_done = 1'b1;
                r.upd_if  = 1'b1;
            end else begin
                r.mem_done = 1'b1;
                r.upd_mem  = 1'b1;
            end
            exp_q.push_back(r);
        end
    endfunction

    // ---------------- compare ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit          cmp_en = 1'b0;
    logic [31:0] m_if   = '0;
    logic [31:0] m_mem  = '0;
    rec_t        cur_r;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (exp_q.size() > 0) cur_r = exp_q.pop_front();
            else                  cur_r = mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0);
            if (cur_r.is_rst) begin
                m_if  = '0;
                m_mem = '0;
            end
            if (cur_r.upd_if)  m_if  = cur_r.data;
            if (cur_r.upd_mem) m_mem = cur_r.data;
            chk("busy", busy_o, cur_r.busy);
            chk("ram_we", ram_we_o, cur_r.we);
            chk("if_done", if_done_o, cur_r.if_done);
            chk("mem_done", mem_done_o, cur_r.mem_done);
            chk("if_data", if_data_o, m_if);
            chk("mem_rdata", mem_rdata_o, m_mem);
            if (cur_r.care_ad) begin
                chk("ram_addr", ram_addr_o, cur_r.addr);
                chk("ram_dout", ram_dout_o, cur_r.dout);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit want_if, output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (want_if ? if_done_o : mem_done_o) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done pulse expected one within 40 cycles at %0t", $time);
        end
    endtask

    task automatic do_txn(input bit is_if, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata, input bit flush);
        int k;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        next_cycle();
        if (is_if) begin
            if_req_i  = 1'b1;
            if_addr_i = addr;
        end else begin
            mem_req_i   = 1'b1;
            mem_we_i    = we;
            mem_len_i   = len;
            mem_addr_i  = addr;
            mem_wdata_i = wdata;
            if_flush_i  = flush;
        end
        push_txn(is_if, we, len, addr, wdata);
        wait_done(is_if, k);
        if_req_i   = 1'b0;
        mem_req_i  = 1'b0;
        if_flush_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          k;
        bit          kind_if;
        bit          kind_we;
        logic [31:0] a;

        rst         = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        if_flush_i  = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_len_i   = '0;
        mem_addr_i  = '0;
        mem_wdata_i = '0;

        // Reset state before any clock edge.
        #2;
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ram_we", ram_we_o, 1'b0);
        chk("rst_ram_addr", ram_addr_o, 32'd0);
        chk("rst_ram_dout", ram_dout_o, 8'd0);
        chk("rst_if_done", if_done_o, 1'b0);
        chk("rst_mem_done", mem_done_o, 1'b0);
        chk("rst_if_data", if_data_o, 32'd0);
        chk("rst_mem_rdata", mem_rdata_o, 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        next_cycle();
        cmp_en = 1'b1;

        // IF word read at 0x100.
        preload(32'h100, 8'h11);
        preload(32'h101, 8'h22);
        preload(32'h102, 8'h33);
        preload(32'h103, 8'h44);
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h100;
        push_txn(1'b1, 1'b0, 2'd2, 32'h100, 32'd0);
        wait_done(1'b1, k);
        chk("if_latency", k, 6);
        chk("if_data_lit", if_data_o, 32'h44332211);
        if_req_i = 1'b0;

        // Simultaneous requests: MEM byte load wins, IF follows after DONE.
        preload(32'h20, 8'hAB);
        preload(32'h200, 8'h01);
        preload(32'h201, 8'h02);
        preload(32'h202, 8'h03);
        preload(32'h203, 8'h04);
        next_cycle();
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_len_i  = 2'd0;
        mem_addr_i = 32'h20;
        if_req_i   = 1'b1;
        if_addr_i  = 32'h200;
        push_txn(1'b0, 1'b0, 2'd0, 32'h20, 32'd0);
        push_txn(1'b1, 1'b0, 2'd2, 32'h200, 32'd0);
        wait_done(1'b0, k);
        chk("arb_mem_latency", k, 3);
        chk("arb_mem_rdata_lit", mem_rdata_o, 32'h000000AB);
        mem_req_i = 1'b0;
        wait_done(1'b1, k);
        chk("arb_if_after_mem", k, 7);
        chk("arb_if_data_lit", if_data_o, 32'h04030201);
        if_req_i = 1'b0;

        // Half store across the address wrap.
        next_cycle();
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_len_i   = 2'd1;
        mem_addr_i  = 32'hFFFF_FFFF;
        mem_wdata_i = 32'h1234_BEEF;
        push_txn(1'b0, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h1234_BEEF);
        wait_done(1'b0, k);
        chk("half_store_latency", k, 3);
        mem_req_i = 1'b0;
        next_cycle();
        chk("wrap_byte_hi", ram_rd(32'hFFFF_FFFF), 8'hEF);
        chk("wrap_byte_lo", ram_rd(32'h0000_0000), 8'hBE);

        // Flush in cycle 2 of an IF read.
        next_cycle();
        if_req_i  = 1'b1;
        if_addr_i = 32'h300;
        exp_q.push_back(mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h300, 1'b0, 8'd0));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h301, 1'b0, 8'd0));
        exp_q.push_back(mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0));
        next_cycle();
        next_cycle();
        if_flush_i = 1'b1;
        next_cycle();
        if_flush_i = 1'b0;
        if_req_i   = 1'b0;
        chk("flush_idle", busy_o, 1'b0);
        chk("flush_if_data_kept", if_data_o, 32'h04030201);
        repeat (8) next_cycle();

        // Reset in cycle 2 of a word store.
        next_cycle();
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_len_i   = 2'd2;
        mem_addr_i  = 32'h500;
        mem_wdata_i = 32'hCAFE_F00D;
        exp_q.push_back(mk(1'b0, 1'b1, 32'd0, 1'b0, 8'd0));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h500, 1'b1, 8'h0D));
        model_mem[32'h500] = 8'h0D;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_rst());
        next_cycle();
        @(posedge clk);
        #2;
        rst       = 1'b0;
        mem_req_i = 1'b0;
        #1;
        chk("midrst_ram_we", ram_we_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        chk("midrst_ram_addr", ram_addr_o, 32'd0);
        chk("midrst_if_data", if_data_o, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) next_cycle();
        chk("midrst_byte0_written", ram_rd(32'h500), 8'h0D);
        chk("midrst_byte1_untouched", ram_rd(32'h501), fill_byte(32'h501));

        // Load address changes after the grant.
        preload(32'h400, 8'hA1);
        preload(32'h401, 8'hB2);
        preload(32'h402, 8'hC3);
        preload(32'h403, 8'hD4);
        next_cycle();
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_len_i  = 2'd2;
        mem_addr_i = 32'h400;
        push_txn(1'b0, 1'b0, 2'd2, 32'h400, 32'd0);
        next_cycle();
        next_cycle();
        mem_addr_i  = 32'h800;
        mem_len_i   = 2'd0;
        mem_we_i    = 1'b1;
        mem_wdata_i = $urandom;
        wait_done(1'b0, k);
        chk("latch_latency_rest", k, 4);
        chk("latch_rdata_lit", mem_rdata_o, 32'hD4C3B2A1);
        mem_req_i = 1'b0;
        mem_we_i  = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            kind_if = ($urandom_range(0, 2) == 0);
            kind_we = kind_if ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'($urandom_range(0, 255));
            do_txn(kind_if, kind_we, 2'($urandom_range(0, 3)), a, $urandom,
                   1'($urandom_range(0, 1)));
        end

        repeat (4) next_cycle();
        chk("trace_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 mem_ctrl SHALL expose these ports:
- clk  in  1  rising-edge clock (single clock domain)
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, level, held until if_done_o
- if_addr_i  in  32  fetch byte address
- if_flush_i  in  1  abort in-flight fetch (branch taken)
- if_data_o  out  32  fetched word
- if_done_o  out  1  one-cycle fetch-complete pulse
- mem_req_i  in  1  load/store request, level, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- mem_addr_i  in  32  load/store byte address
- mem_wdata_i  in  32  store data, little-endian
- mem_rdata_o  out  32  load data, zero-extended raw bytes
- mem_done_o  out  1  one-cycle load/store-complete pulse
- ram_addr_o  out  32  byte-wide RAM address
- ram_we_o  out  1  RAM write enable
- ram_dout_o  out  8  RAM write byte
- ram_din_i  in  8  RAM read byte, valid one cycle after its address
- busy_o  out  1  controller not idle; feeds pipeline stall request
REQ-002 The block SHALL use one clock, clk; rst SHALL be asynchronous and active-low.

Function
REQ-003 The block SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR and DONE.
REQ-004 In IDLE, a grant SHALL occur when either request is high; mem_req_i SHALL win over if_req_i when both are high.
REQ-005 The grant SHALL latch the address, len, we and wdata; later changes to the request inputs SHALL be ignored until DONE.
REQ-006 Byte count N SHALL be 4 for IF and 1, 2 or 4 for MEM according to mem_len_i; len 3 SHALL be treated as 4.
REQ-007 Read sequencing: in busy cycles 1..N after the grant cycle 0, ram_addr_o SHALL equal base+(c-1), with ram_we_o=0.
REQ-008 Read capture: the byte on ram_din_i in cycle c+1 SHALL be stored at byte lane c-1 of the result; unfetched lanes SHALL read 0.
REQ-009 Read completion: done SHALL pulse in cycle N+2 (word read: cycle 6), with rdata or if_data valid in that same cycle.
REQ-010 Write sequencing: in cycles 1..N, ram_we_o SHALL be 1, with ram_addr_o = base+(c-1) and ram_dout_o = wdata byte c-1.
REQ-011 Write completion: mem_done_o SHALL pulse in cycle N+1.
REQ-012 Address increments SHALL wrap modulo 2^32.
REQ-013 The done pulse SHALL be issued from DONE; DONE SHALL always go to IDLE and SHALL NOT grant.
REQ-014 When not busy, ram_we_o, ram_addr_o and ram_dout_o SHALL be 0.
REQ-015 if_flush_i high during IF_RD SHALL return the FSM to IDLE at the next edge, with no if_done_o pulse.
REQ-016 if_flush_i high in IDLE SHALL suppress an IF grant in that cycle; an MEM grant SHALL still occur.
REQ-017 if_flush_i SHALL be ignored during MEM_RD and MEM_WR.
REQ-018 if_data_o and mem_rdata_o SHALL hold their last completed value between transfers.
REQ-019 busy_o SHALL be 1 in every state except IDLE.
REQ-020 if_done_o and mem_done_o SHALL never be asserted in the same cycle.

Reset
REQ-021 While rst=0, the FSM SHALL be in IDLE and every output SHALL be 0, independent of clk.
REQ-022 Reset asserted mid-transfer SHALL abandon the transfer, with no done pulse and no further RAM write.

Structure
REQ-023 The FSM state encoding and the len codes (LEN_B, LEN_H, LEN_W) SHALL live in the shared defines package.
REQ-024 A single sub-module, mem_byte_lane, SHALL handle byte-lane selection and insertion for both reads and writes.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- IF word read at 0x100, with RAM bytes 11,22,33,44 -> addresses 0x100..0x103 in cycles 1..4, if_data_o=0x44332211, if_done_o in cycle 6.
- Same-cycle if_req and mem load byte at 0x20 (0xAB) -> MEM granted first, mem_rdata_o=0x000000AB; IF granted after MEM's DONE.
- Half store 0xBEEF to 0xFFFFFFFF -> writes EF@0xFFFFFFFF then BE@0x00000000, mem_done_o in cycle 3.
- if_flush_i in cycle 2 of an IF read -> IDLE next cycle, no if_done_o, if_data_o unchanged.
- rst low in cycle 2 of a word store -> outputs 0 immediately, ram_we_o stays 0, no mem_done_o.
- mem_addr_i changed mid-load -> bytes still fetched from the latched base address.
